// File: rtl/seg7_hex_scanner.sv
// Two-digit multiplexed hex display driver with frame-synchronous,
// double-buffered value commit so a new value never tears on screen.
module seg7_hex_scanner #(
  parameter int REFRESH_DIV    = 50000,
  parameter int CNT_W          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] d_in,
  input  logic       blank,
  output logic       load_ack,
  output logic       frame_tick,
  output logic       seg_tg_out,
  output logic [6:0] seg
);

  localparam logic [6:0] OFF =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [7:0]       shadow;
  logic [7:0]       disp;
  logic             pending;

  logic             slot_end;
  logic             frame_end;
  logic             commit;
  logic [7:0]       disp_nxt;
  logic [3:0]       nib;
  logic             lz_off;
  logic [6:0]       seg_nxt;

  function automatic logic [6:0] hex7(
    input logic [3:0] v
  );
    logic [6:0] p;
    p = 7'h00;
    case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // seg is loaded for the digit being switched to, so the
  // nibble choice looks at the inverse of the current select.
  always_comb begin
    slot_end  = (cnt == LAST);
    frame_end = slot_end & seg_tg_out;
    commit    = frame_end & pending;
    disp_nxt  = commit ? shadow : disp;
    nib       = seg_tg_out ? disp_nxt[3:0]
                           : disp_nxt[7:4];
    lz_off    = BLANK_LZ && !seg_tg_out &&
                (disp_nxt[7:4] == 4'h0);
    seg_nxt   = hex7(nib) ^ {7{SEG_ACTIVE_LOW}};
    if (blank || lz_off) seg_nxt = OFF;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      seg_tg_out <= 1'b0;
      shadow     <= 8'h00;
      disp       <= 8'h00;
      pending    <= 1'b0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
      seg        <= OFF;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      frame_tick <= frame_end;
      load_ack   <= commit;
      disp       <= disp_nxt;
      if (slot_end) begin
        seg_tg_out <= ~seg_tg_out;
        seg        <= seg_nxt;
      end
      // a load on the commit edge re-arms for the next frame
      if (load) begin
        shadow  <= d_in;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_hex_scanner.sv
// Scoreboard bench for seg7_hex_scanner: three parameter variants
// share stimulus and are checked against a slot-level model.
module tb_seg7_hex_scanner;

  localparam int D = 4;
  localparam int N = 3;
  // per-instance: active-low polarity and leading-zero blanking
  localparam logic [N-1:0] AL = 3'b011;
  localparam logic [N-1:0] LZ = 3'b010;
  localparam logic [15:0][6:0] LIT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic              tg;
    logic              ack;
    logic [N-1:0][6:0] s;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] d_in;
  logic       blank;
  logic [6:0] seg [N];
  logic       tg  [N];
  logic       ack [N];
  logic       ft  [N];

  int   checks = 0;
  int   errors = 0;
  rec_t q[$];

  always #5 clk = ~clk;

  seg7_hex_scanner #(
    .REFRESH_DIV(D), .CNT_W(3),
    .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)
  ) u0 (
    .clk(clk), .rst(rst), .load(load), .d_in(d_in),
    .blank(blank), .load_ack(ack[0]),
    .frame_tick(ft[0]), .seg_tg_out(tg[0]),
    .seg(seg[0])
  );

  seg7_hex_scanner #(
    .REFRESH_DIV(D), .CNT_W(3),
    .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
  ) u1 (
    .clk(clk), .rst(rst), .load(load), .d_in(d_in),
    .blank(blank), .load_ack(ack[1]),
    .frame_tick(ft[1]), .seg_tg_out(tg[1]),
    .seg(seg[1])
  );

  seg7_hex_scanner #(
    .REFRESH_DIV(D), .CNT_W(3),
    .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)
  ) u2 (
    .clk(clk), .rst(rst), .load(load), .d_in(d_in),
    .blank(blank), .load_ack(ack[2]),
    .frame_tick(ft[2]), .seg_tg_out(tg[2]),
    .seg(seg[2])
  );

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(
    input int i, input logic [3:0] n, input logic off
  );
    logic [6:0] v;
    v = off ? 7'h00 : LIT[n];
    return AL[i] ? ~v : v;
  endfunction

  // Reference: k = clock edges since reset release. Every D-th edge
  // starts a slot; even slots show the low digit and open a frame.
  int         k = 0;
  logic [7:0] m_sh = 8'h00;
  logic [7:0] m_disp = 8'h00;
  logic       m_pend = 1'b0;
  logic       in_rst = 1'b1;

  always @(posedge clk) begin
    rec_t       r;
    int         dig;
    logic [3:0] nb;
    logic       off;
    in_rst = !rst;
    if (!rst) begin
      k = 0;
      m_sh = 8'h00;
      m_disp = 8'h00;
      m_pend = 1'b0;
      q.delete();
    end else begin
      k++;
      if (k % D == 0) begin
        dig = (k / D) % 2;
        r = '0;
        r.tg = (dig == 1);
        if (dig == 0) begin
          r.ack = m_pend;
          if (m_pend) m_disp = m_sh;
          m_pend = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          nb  = (dig == 1) ? m_disp[7:4] : m_disp[3:0];
          off = blank || (LZ[i] && dig == 1 &&
                          m_disp[7:4] == 4'h0);
          r.s[i] = exp_seg(i, nb, off);
        end
        q.push_back(r);
      end
      if (load) begin
        m_sh = d_in;
        m_pend = 1'b1;
      end
    end
  end

  int   since = 0;
  logic prev_tg = 1'b0;
  int   ack_cnt = 0;

  always @(negedge clk) begin
    rec_t r;
    if (in_rst) begin
      for (int i = 0; i < N; i++) begin
        chk("rst_seg", 32'(seg[i]),
            AL[i] ? 32'h7F : 32'h00);
        chk("rst_tg", 32'(tg[i]), 0);
        chk("rst_ack", 32'(ack[i]), 0);
        chk("rst_frame", 32'(ft[i]), 0);
      end
      since = 0;
      prev_tg = 1'b0;
    end else begin
      since++;
      if (ack[0] === 1'b1) ack_cnt++;
      if (tg[0] !== prev_tg) begin
        chk("period", since, D);
        since = 0;
        prev_tg = tg[0];
        chk("sb_depth", q.size(), 1);
        if (q.size() > 0) begin
          r = q.pop_front();
          for (int i = 0; i < N; i++) begin
            chk("tg", 32'(tg[i]), 32'(r.tg));
            chk("seg", 32'(seg[i]), 32'(r.s[i]));
            chk("ack", 32'(ack[i]), 32'(r.ack));
            chk("frame", 32'(ft[i]), 32'(!r.tg));
          end
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          chk("ack_idle", 32'(ack[i]), 0);
          chk("frame_idle", 32'(ft[i]), 0);
        end
      end
    end
  end

  task automatic step(input logic ld, input logic [7:0] d);
    load = ld;
    d_in = d;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  // run until the next edge will be at frame phase ph
  task automatic wait_phase(input int ph);
    for (int j = 0; j < 2 * D; j++) begin
      if ((k + 1) % (2 * D) == ph) break;
      idle(1);
    end
  endtask

  task automatic wait_ack(input string name);
    bit got;
    got = 1'b0;
    for (int j = 0; j < 2 * D + 1; j++) begin
      idle(1);
      if (ack[0] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 32'(got), 1);
  endtask

  int a0;

  initial begin
    rst = 1'b0;
    load = 1'b0;
    d_in = 8'h00;
    blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(20);

    wait_phase(3);
    step(1'b1, 8'h3A);
    wait_ack("ack_3a");
    chk("lo_3a", 32'(seg[0]), 32'h08);
    idle(D);
    chk("hi_3a", 32'(seg[0]), 32'h30);

    wait_phase(1);
    a0 = ack_cnt;
    step(1'b1, 8'h12);
    step(1'b1, 8'hC5);
    wait_ack("ack_c5");
    chk("lo_c5", 32'(seg[0]), 32'h12);
    idle(D);
    chk("hi_c5", 32'(seg[0]), 32'h46);
    idle(2 * D);
    chk("one_ack_c5", ack_cnt - a0, 1);

    wait_phase(1);
    step(1'b1, 8'h07);
    wait_ack("ack_07");
    chk("lo_07_lz", 32'(seg[1]), 32'h78);
    idle(D);
    chk("hi_07_lz", 32'(seg[1]), 32'h7F);
    blank = 1'b1;
    idle(D);
    chk("blank_u0", 32'(seg[0]), 32'h7F);
    chk("blank_u1", 32'(seg[1]), 32'h7F);
    chk("blank_u2", 32'(seg[2]), 32'h00);
    idle(D);
    blank = 1'b0;
    idle(2 * D);

    wait_phase(1);
    a0 = ack_cnt;
    step(1'b1, 8'hFF);
    idle(2);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(3 * D);
    chk("no_ack_rst", ack_cnt - a0, 0);
    chk("zero_after_rst", 32'(seg[0]), 32'h40);

    wait_phase(2);
    a0 = ack_cnt;
    step(1'b1, 8'h5E);
    wait_phase(0);
    step(1'b1, 8'hB4);
    idle(3 * D);
    chk("two_acks", ack_cnt - a0, 2);

    for (int j = 0; j < 600; j++) begin
      rst = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 39) == 0) blank = ~blank;
      step($urandom_range(0, 4) == 0, 8'($urandom));
    end

    rst = 1'b1;
    blank = 1'b0;
    idle(3 * D);
    @(negedge clk);
    #1;
    chk("sb_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual running required done");
    $fatal(1, "timeout");
  end

endmodule
